// File: rtl/arb_mux2_pkg.sv
// Shared types and constants for the two-source round-robin stream arbiter.
package arb_mux2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request round-robin pick; the priority pointer is owned by the caller.
module rr_arb2
    import arb_mux2_pkg::*;
(
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic       pri_i,
    output logic [1:0] gnt_o
);

    logic win_b;

    always_comb begin
        win_b = 1'b0;
        if (req_a_i && req_b_i) begin
            win_b = (pri_i == SEL_B);
        end else if (req_b_i) begin
            win_b = 1'b1;
        end
        gnt_o = 2'b00;
        if (req_a_i || req_b_i) begin
            gnt_o = win_b ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/arb_mux2.sv
// Packet-granular round-robin arbiter over two valid/ready sources with a
// registered output stage and a registered select for the downstream 2:1 mux.
module arb_mux2
    import arb_mux2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             pri_q, pri_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic             y_last_q, y_last_d;
    logic             y_valid_q, y_valid_d;

    logic       load_en;
    logic       a_xfer, b_xfer, eop;
    logic [1:0] gnt;

    // Ready depends only on state and the output register, never on a valid.
    always_comb begin
        load_en = !y_valid_q || y_ready;
        a_ready = (state_q == GRANT_A) && load_en;
        b_ready = (state_q == GRANT_B) && load_en;
        a_xfer  = a_valid && a_ready;
        b_xfer  = b_valid && b_ready;
        eop     = (a_xfer && a_last) || (b_xfer && b_last);
        pri_d   = pri_q;
        if (eop) begin
            pri_d = (state_q == GRANT_A) ? SEL_B : SEL_A;
        end
    end

    // Arbitrating against the already-flipped pointer gives back-to-back packets.
    rr_arb2 u_rr_arb2 (
        .req_a_i (a_valid),
        .req_b_i (b_valid),
        .pri_i   (pri_d),
        .gnt_o   (gnt)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        y_data_d  = y_data_q;
        y_last_d  = y_last_q;
        y_valid_d = y_valid_q;

        if (state_q == IDLE || eop) begin
            if (gnt[0]) begin
                state_d = GRANT_A;
            end else if (gnt[1]) begin
                state_d = GRANT_B;
            end else begin
                state_d = IDLE;
            end
        end

        if (state_d == GRANT_A) begin
            sel_d = SEL_A;
        end else if (state_d == GRANT_B) begin
            sel_d = SEL_B;
        end

        if (a_xfer) begin
            y_data_d  = a_data;
            y_last_d  = a_last;
            y_valid_d = 1'b1;
        end else if (b_xfer) begin
            y_data_d  = b_data;
            y_last_d  = b_last;
            y_valid_d = 1'b1;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pri_q     <= SEL_A;
            sel_q     <= SEL_A;
            y_data_q  <= '0;
            y_last_q  <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pri_q     <= pri_d;
            sel_q     <= sel_d;
            y_data_q  <= y_data_d;
            y_last_q  <= y_last_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y_data  = y_data_q;
    assign y_last  = y_last_q;
    assign y_valid = y_valid_q;
    assign sel     = sel_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_arb_mux2.sv
// Scoreboard bench for arb_mux2: source drivers feed beat queues, a monitor
// pops expected {last,data} beats whenever the output handshakes.
module tb_arb_mux2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data, y_data;
    logic       a_valid, a_last, a_ready;
    logic       b_valid, b_last, b_ready;
    logic       y_valid, y_last, y_ready;
    logic       sel, busy;

    int checks = 0;
    int fails  = 0;

    logic [8:0] a_q[$];
    logic [8:0] b_q[$];
    logic [8:0] sb_q[$];

    arb_mux2 #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_last  (b_last),
        .b_ready (b_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_last  (y_last),
        .y_ready (y_ready),
        .sel     (sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    // Source A driver: inputs change 1 time unit after the rising edge.
    initial begin : drv_a
        logic acc;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        forever begin
            @(negedge clk);
            acc = a_valid && a_ready;
            @(posedge clk);
            #1;
            if (acc && a_q.size() > 0) void'(a_q.pop_front());
            if (!rst && a_q.size() > 0) begin
                a_valid = 1'b1;
                {a_last, a_data} = a_q[0];
            end else begin
                a_valid = 1'b0;
            end
        end
    end

    initial begin : drv_b
        logic acc;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        forever begin
            @(negedge clk);
            acc = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (acc && b_q.size() > 0) void'(b_q.pop_front());
            if (!rst && b_q.size() > 0) begin
                b_valid = 1'b1;
                {b_last, b_data} = b_q[0];
            end else begin
                b_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [8:0] exp_beat;
        forever begin
            @(negedge clk);
            if (!rst && y_valid && y_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL y_beat_unexpected: got 0x%0h, expected none", {y_last, y_data});
                end else begin
                    exp_beat = sb_q.pop_front();
                    check("y_beat", {23'd0, y_last, y_data}, {23'd0, exp_beat});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_q.delete();
        b_q.delete();
        sb_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_a(input logic [7:0] d, input logic l);
        a_q.push_back({l, d});
    endtask

    task automatic push_b(input logic [7:0] d, input logic l);
        b_q.push_back({l, d});
    endtask

    task automatic wait_sb_empty(input string name, input int budget, output int cycles);
        cycles = 0;
        while (sb_q.size() != 0 && cycles < budget) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: got %0d beats pending, expected 0", name, sb_q.size());
        end
    endtask

    task automatic wait_y_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!y_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_y_valid_seen"}, {31'd0, y_valid}, 32'd1);
    endtask

    // Called at the tick where A's first beat was queued (one cycle before cycle 0).
    task automatic check_latency(input string name, input logic [7:0] first);
        tick();
        @(negedge clk); #1;
        check({name, "_c0_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_c0_a_ready"}, {31'd0, a_ready}, 32'd0);
        @(negedge clk); #1;
        check({name, "_c1_busy"}, {31'd0, busy}, 32'd1);
        check({name, "_c1_sel"}, {31'd0, sel}, 32'd0);
        check({name, "_c1_a_ready"}, {31'd0, a_ready}, 32'd1);
        check({name, "_c1_y_valid"}, {31'd0, y_valid}, 32'd0);
        @(negedge clk); #1;
        check({name, "_c2_y_valid"}, {31'd0, y_valid}, 32'd1);
        check({name, "_c2_y_data"}, {24'd0, y_data}, {24'd0, first});
    endtask

    initial begin : main
        int cyc;
        logic seen_b;
        rst = 1'b1;
        y_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Asynchronous reset while a beat is held in the output register.
        push_a(8'h99, 1'b1);
        wait_y_valid("rst_async");
        rst = 1'b1;
        #1;
        check("rst_y_valid", {31'd0, y_valid}, 32'd0);
        check("rst_y_data", {24'd0, y_data}, 32'd0);
        check("rst_y_last", {31'd0, y_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sel", {31'd0, sel}, 32'd0);
        check("rst_readies", {30'd0, a_ready, b_ready}, 32'd0);
        do_reset();
        y_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_sel", {31'd0, sel}, 32'd0);
        end

        // Single three-beat packet from A.
        do_reset();
        y_ready = 1'b1;
        push_a(8'h11, 1'b0); push_a(8'h22, 1'b0); push_a(8'h33, 1'b1);
        sb_q.push_back({1'b0, 8'h11}); sb_q.push_back({1'b0, 8'h22}); sb_q.push_back({1'b1, 8'h33});
        check_latency("single", 8'h11);
        check("single_c2_y_last", {31'd0, y_last}, 32'd0);
        @(negedge clk); #1;
        check("single_c3_y_data", {24'd0, y_data}, 32'h22);
        @(negedge clk); #1;
        check("single_c4_y_data", {24'd0, y_data}, 32'h33);
        check("single_c4_y_last", {31'd0, y_last}, 32'd1);
        wait_sb_empty("single", 10, cyc);

        // Continuous contention with 2-beat packets: strict A/B alternation, no bubbles.
        do_reset();
        y_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            push_a(8'hA0 + 8'(2 * p), 1'b0); push_a(8'hA1 + 8'(2 * p), 1'b1);
            push_b(8'hB0 + 8'(2 * p), 1'b0); push_b(8'hB1 + 8'(2 * p), 1'b1);
        end
        for (int p = 0; p < 4; p++) begin
            sb_q.push_back({1'b0, 8'hA0 + 8'(2 * p)}); sb_q.push_back({1'b1, 8'hA1 + 8'(2 * p)});
            sb_q.push_back({1'b0, 8'hB0 + 8'(2 * p)}); sb_q.push_back({1'b1, 8'hB1 + 8'(2 * p)});
        end
        wait_sb_empty("contend", 60, cyc);
        check("contend_no_bubble", {31'd0, (cyc <= 19)}, 32'd1);

        // Output backpressure holds the first beat for three cycles.
        do_reset();
        y_ready = 1'b0;
        push_a(8'h5A, 1'b0); push_a(8'h6B, 1'b0); push_a(8'h7C, 1'b0); push_a(8'h8D, 1'b1);
        sb_q.push_back({1'b0, 8'h5A}); sb_q.push_back({1'b0, 8'h6B});
        sb_q.push_back({1'b0, 8'h7C}); sb_q.push_back({1'b1, 8'h8D});
        wait_y_valid("bp");
        repeat (3) begin
            check("bp_hold_data", {24'd0, y_data}, 32'h5A);
            check("bp_hold_valid", {31'd0, y_valid}, 32'd1);
            check("bp_a_ready", {31'd0, a_ready}, 32'd0);
            @(negedge clk); #1;
        end
        tick();
        y_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_release_data", {24'd0, y_data}, 32'h5A);
        @(negedge clk); #1;
        check("bp_next_data", {24'd0, y_data}, 32'h6B);
        wait_sb_empty("bp", 10, cyc);

        // B arrives mid-way through an A packet and must wait for A's last beat.
        do_reset();
        y_ready = 1'b1;
        push_a(8'hC0, 1'b0); push_a(8'hC1, 1'b0); push_a(8'hC2, 1'b0); push_a(8'hC3, 1'b1);
        sb_q.push_back({1'b0, 8'hC0}); sb_q.push_back({1'b0, 8'hC1});
        sb_q.push_back({1'b0, 8'hC2}); sb_q.push_back({1'b1, 8'hC3});
        repeat (2) tick();
        push_b(8'hD0, 1'b0); push_b(8'hD1, 1'b1);
        sb_q.push_back({1'b0, 8'hD0}); sb_q.push_back({1'b1, 8'hD1});
        seen_b = 1'b0;
        for (int i = 0; i < 20 && !seen_b; i++) begin
            @(negedge clk); #1;
            if (a_q.size() > 0) begin
                check("ilv_b_ready_blocked", {31'd0, b_ready}, 32'd0);
            end else begin
                check("ilv_b_ready_after_last", {31'd0, b_ready}, 32'd1);
                seen_b = 1'b1;
            end
        end
        check("ilv_b_granted", {31'd0, seen_b}, 32'd1);
        wait_sb_empty("ilv", 10, cyc);
        check("ilv_no_bubble", {31'd0, (cyc <= 3)}, 32'd1);

        // Reset after two of four beats; A then restarts from IDLE.
        do_reset();
        y_ready = 1'b1;
        push_a(8'hE0, 1'b0); push_a(8'hE1, 1'b0); push_a(8'hE2, 1'b0); push_a(8'hE3, 1'b1);
        sb_q.push_back({1'b0, 8'hE0}); sb_q.push_back({1'b0, 8'hE1});
        sb_q.push_back({1'b0, 8'hE2}); sb_q.push_back({1'b1, 8'hE3});
        cyc = 0;
        while (sb_q.size() > 2 && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("midrst_two_beats", sb_q.size(), 32'd2);
        rst = 1'b1;
        #1;
        check("midrst_y_valid", {31'd0, y_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        do_reset();
        push_a(8'hF0, 1'b0); push_a(8'hF1, 1'b1);
        sb_q.push_back({1'b0, 8'hF0}); sb_q.push_back({1'b1, 8'hF1});
        check_latency("midrst", 8'hF0);
        wait_sb_empty("midrst", 10, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
